// File: rtl/rr_grant_arbiter3.sv
// Three-requester round-robin arbiter with a registered one-hot grant.
// An owner may keep the grant for at most HOLD_MAX cycles while others wait.
module rr_grant_arbiter3 #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] w,
  output logic [2:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic [3:0] hold_cnt
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [1:0] id_nxt;
  logic [1:0] sel;
  logic [2:0] gnt_nxt;
  logic [3:0] hold_nxt;
  logic [2:0] others;
  logic [2:0] cand;
  logic       keep;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // First asserted candidate scanning p, p+1, p+2 (mod 3); lowest offset wins.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [2:0] c);
    logic [1:0] r;
    logic [1:0] i;
    r = p;
    for (int k = 2; k >= 0; k--) begin
      i = wrap3({1'b0, p} + 3'(k));
      if (c[i]) r = i;
    end
    return r;
  endfunction

  // When the owner is being forced off, it is excluded from the scan.
  assign others = w & ~gnt;
  assign cand   = (others != 3'b000) ? others : w;
  assign keep   = gnt_valid && ((w & gnt) != 3'b000) &&
                  ((hold_cnt < HOLD_LIM) || (others == 3'b000));
  assign sel    = pick(ptr, cand);

  always_comb begin
    gnt_nxt  = 3'b000;
    id_nxt   = 2'd0;
    hold_nxt = 4'd0;
    ptr_nxt  = ptr;
    if (keep) begin
      gnt_nxt  = gnt;
      id_nxt   = gnt_id;
      hold_nxt = (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
    end else if (w != 3'b000) begin
      gnt_nxt  = 3'b001 << sel;
      id_nxt   = sel;
      ptr_nxt  = wrap3({1'b0, sel} + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 3'b000;
      gnt_id   <= 2'd0;
      hold_cnt <= 4'd0;
      ptr      <= 2'd0;
    end else begin
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      hold_cnt <= hold_nxt;
      ptr      <= ptr_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_grant_arbiter3.sv
// Bench for rr_grant_arbiter3: behavioural model compared every cycle,
// directed scenarios with literal expectations, and a random fairness phase.
module tb_rr_grant_arbiter3;
  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] w = 3'b000;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] hold_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rr_grant_arbiter3 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .w(w), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner, how long it has held, and where the next scan starts.
  bit       m_valid;
  int       m_id, m_hold, m_ptr;
  bit [2:0] w_smp;
  int       wait_cnt [3];

  always @(posedge clk or negedge rst_n) begin
    bit any_other, own_req;
    int nid;
    if (!rst_n) begin
      m_valid <= 0; m_id <= 0; m_hold <= 0; m_ptr <= 0; w_smp <= 3'b000;
    end else begin
      w_smp <= w;
      any_other = 0;
      for (int i = 0; i < 3; i++)
        if (w[i] && !(m_valid && i == m_id)) any_other = 1;
      own_req = m_valid && w[m_id];
      if (own_req && (m_hold < HOLD_MAX - 1 || !any_other)) begin
        m_hold <= (m_hold == 15) ? 15 : m_hold + 1;
      end else if (w == 3'b000) begin
        m_valid <= 0; m_id <= 0; m_hold <= 0;
      end else begin
        nid = -1;
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_ptr + k) % 3;
          if (nid < 0 && w[i] && !(m_valid && i == m_id && any_other)) nid = i;
        end
        m_valid <= 1; m_id <= nid; m_hold <= 0; m_ptr <= (nid + 1) % 3;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("gnt", gnt, m_valid ? (1 << m_id) : 0);
    chk("gnt_valid", gnt_valid, m_valid);
    chk("gnt_id", gnt_id, m_valid ? m_id : 0);
    chk("hold_cnt", hold_cnt, m_hold);
    chk("onehot", $countones(gnt) <= 1, 1);
    chk("gnt_in_w", (gnt & ~w_smp) == 3'b000, 1);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || !w_smp[i] || (gnt_valid && gnt_id == 2'(i))) wait_cnt[i] = 0;
      else begin
        wait_cnt[i]++;
        chk($sformatf("fair%0d", i), wait_cnt[i] <= 2 * HOLD_MAX, 1);
      end
    end
  end

  task automatic cyc(input logic [2:0] wv);
    @(negedge clk);
    w = wv;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] seq2 [13] = '{3'b001, 3'b001, 3'b001, 3'b001,
                            3'b010, 3'b010, 3'b010, 3'b010,
                            3'b100, 3'b100, 3'b100, 3'b100, 3'b001};

  initial begin
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_hold", hold_cnt, 0);
    chk("rst_id", gnt_id, 0);
    @(negedge clk) rst_n = 1'b1;

    // Single request from requester 2, then idle.
    cyc(3'b100);
    chk("t1_gnt", gnt, 3'b100);
    chk("t1_id", gnt_id, 2);
    cyc(3'b000);
    chk("t1_idle", gnt, 0);
    chk("t1_idle_valid", gnt_valid, 0);

    // All request: ptr back at 0, four cycles each.
    for (int c = 0; c < 13; c++) begin
      cyc(3'b111);
      chk($sformatf("t2_seq%0d", c), gnt, seq2[c]);
    end

    // Lone requester keeps the grant; hold saturates.
    for (int c = 0; c < 20; c++) cyc(3'b001);
    chk("t3_gnt", gnt, 3'b001);
    chk("t3_hold", hold_cnt, 15);

    // Owner drops while another arrives: no bubble.
    cyc(3'b010);
    chk("t4_gnt", gnt, 3'b010);
    chk("t4_hold", hold_cnt, 0);

    // Asynchronous reset mid-grant.
    cyc(3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", gnt, 0);
    chk("t5_async_valid", gnt_valid, 0);
    @(negedge clk);
    w = 3'b110;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_release", gnt, 3'b010);

    // Wrap-around: owner 2 forced off, ptr wraps to 0.
    cyc(3'b100);
    for (int c = 0; c < 4; c++) cyc(3'b101);
    chk("wrap", gnt, 3'b001);

    for (int c = 0; c < 3000; c++) cyc(3'($urandom_range(0, 7)));
    cyc(3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
